// File: rtl/sigma_icp_accumulator.sv
// Per-frame ICP residual energy: sums i_diff^2 and counts contributing pixels,
// through a 3-stage pipeline (input reg, square, accumulate).
module sigma_icp_accumulator #(
  parameter int SATURATE  = 1,
  parameter int CLOUD_BW  = 16,
  parameter int H_SIZE_BW = 10,
  parameter int V_SIZE_BW = 9
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_frame_start,
  input  logic                           i_frame_end,
  input  logic                           i_valid,
  input  logic                           i_corresp,
  input  logic [CLOUD_BW-1:0]            i_diff,
  output logic                           o_frame_end,
  output logic [4*CLOUD_BW-1:0]          o_sigma_s_icp,
  output logic [H_SIZE_BW+V_SIZE_BW-1:0] o_corresp_count
);

  localparam int SQ_W  = 2 * CLOUD_BW;
  localparam int SUM_W = 4 * CLOUD_BW;
  localparam int CNT_W = H_SIZE_BW + V_SIZE_BW;

  // Largest positive signed value, so downstream signed division stays valid.
  localparam logic [SUM_W:0] SUM_MAX = {2'b00, {(SUM_W-1){1'b1}}};

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [0:0]          state_q, state_d;

  logic                d1_vld_q, d1_vld_d;
  logic                d1_start_q, d1_start_d;
  logic                d1_end_q, d1_end_d;
  logic [CLOUD_BW-1:0] d1_diff_q, d1_diff_d;

  logic                d2_vld_q, d2_vld_d;
  logic                d2_start_q, d2_start_d;
  logic                d2_end_q, d2_end_d;
  logic [SQ_W-1:0]     d2_sq_q, d2_sq_d;

  logic [SUM_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                frame_end_q, frame_end_d;
  logic [SUM_W-1:0]    sigma_q, sigma_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic                in_frame;
  logic signed [SQ_W-1:0] diff_ext;
  logic signed [SQ_W-1:0] sq_s;
  logic [SUM_W-1:0]    acc_base;
  logic [CNT_W-1:0]    cnt_base;
  logic [SQ_W-1:0]     add_sq;
  logic [SUM_W:0]      sum_ext;
  logic [CNT_W:0]      cnt_ext;

  always_comb begin
    // A start pulse opens the frame in its own cycle, even from IDLE.
    in_frame   = (state_q == ST_ACTIVE) || i_frame_start;
    d1_vld_d   = i_valid && i_corresp && in_frame;
    d1_start_d = i_frame_start;
    d1_end_d   = i_frame_end && in_frame;
    d1_diff_d  = i_diff;

    state_d = state_q;
    if (i_frame_start) begin
      state_d = i_frame_end ? ST_IDLE : ST_ACTIVE;
    end else if (i_frame_end) begin
      state_d = ST_IDLE;
    end

    diff_ext   = {{CLOUD_BW{d1_diff_q[CLOUD_BW-1]}}, d1_diff_q};
    sq_s       = diff_ext * diff_ext;
    d2_sq_d    = sq_s;
    d2_vld_d   = d1_vld_q;
    d2_start_d = d1_start_q;
    d2_end_d   = d1_end_q;

    // Start tag discards whatever partial sum a dropped/restarted frame left.
    acc_base = d2_start_q ? '0 : acc_q;
    cnt_base = d2_start_q ? '0 : cnt_q;
    add_sq   = d2_vld_q ? d2_sq_q : '0;
    sum_ext  = {1'b0, acc_base} + {{(SUM_W-SQ_W+1){1'b0}}, add_sq};
    cnt_ext  = {1'b0, cnt_base} + {{CNT_W{1'b0}}, d2_vld_q};

    if ((SATURATE != 0) && (sum_ext > SUM_MAX)) begin
      acc_d = SUM_MAX[SUM_W-1:0];
    end else begin
      acc_d = sum_ext[SUM_W-1:0];
    end

    if ((SATURATE != 0) && cnt_ext[CNT_W]) begin
      cnt_d = '1;
    end else begin
      cnt_d = cnt_ext[CNT_W-1:0];
    end

    frame_end_d = d2_end_q;
    sigma_d     = d2_end_q ? acc_d : sigma_q;
    count_d     = d2_end_q ? cnt_d : count_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      d1_vld_q    <= 1'b0;
      d1_start_q  <= 1'b0;
      d1_end_q    <= 1'b0;
      d1_diff_q   <= '0;
      d2_vld_q    <= 1'b0;
      d2_start_q  <= 1'b0;
      d2_end_q    <= 1'b0;
      d2_sq_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      frame_end_q <= 1'b0;
      sigma_q     <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      d1_vld_q    <= d1_vld_d;
      d1_start_q  <= d1_start_d;
      d1_end_q    <= d1_end_d;
      d1_diff_q   <= d1_diff_d;
      d2_vld_q    <= d2_vld_d;
      d2_start_q  <= d2_start_d;
      d2_end_q    <= d2_end_d;
      d2_sq_q     <= d2_sq_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      frame_end_q <= frame_end_d;
      sigma_q     <= sigma_d;
      count_q     <= count_d;
    end
  end

  assign o_frame_end     = frame_end_q;
  assign o_sigma_s_icp   = sigma_q;
  assign o_corresp_count = count_q;

endmodule

// File: tb/tb_sigma_icp_accumulator.sv
// Directed bench: a saturating and a wrapping instance share the same stimulus;
// frame results are logged at o_frame_end and compared against hand-computed values.
module tb_sigma_icp_accumulator;

  localparam int CBW   = 8;
  localparam int SUM_W = 4 * CBW;
  localparam int CNT_W = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             fs = 1'b0, fe = 1'b0, vld = 1'b0, cor = 1'b0;
  logic [CBW-1:0]   diff = '0;
  logic             fe1, fe0;
  logic [SUM_W-1:0] s1, s0;
  logic [CNT_W-1:0] c1, c0;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned edge_n = 0;

  typedef struct {
    int unsigned      e;
    logic             f1;
    logic             f0;
    logic [SUM_W-1:0] s1;
    logic [CNT_W-1:0] c1;
    logic [SUM_W-1:0] s0;
    logic [CNT_W-1:0] c0;
  } pulse_t;
  pulse_t pq[$];

  typedef struct {
    int unsigned n;
    logic [31:0] d;
    logic [3:0]  cor;
    logic [3:0]  val;
    logic [31:0] es;
    logic [5:0]  ec;
  } frame_t;
  frame_t ft[5];

  sigma_icp_accumulator #(.SATURATE(1), .CLOUD_BW(CBW), .H_SIZE_BW(3), .V_SIZE_BW(3)) u_sat (
    .i_clk(clk), .i_rst(rst), .i_frame_start(fs), .i_frame_end(fe), .i_valid(vld),
    .i_corresp(cor), .i_diff(diff), .o_frame_end(fe1), .o_sigma_s_icp(s1), .o_corresp_count(c1));

  sigma_icp_accumulator #(.SATURATE(0), .CLOUD_BW(CBW), .H_SIZE_BW(3), .V_SIZE_BW(3)) u_wrap (
    .i_clk(clk), .i_rst(rst), .i_frame_start(fs), .i_frame_end(fe), .i_valid(vld),
    .i_corresp(cor), .i_diff(diff), .o_frame_end(fe0), .o_sigma_s_icp(s0), .o_corresp_count(c0));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fe1 || fe0) pq.push_back('{edge_n, fe1, fe0, s1, c1, s0, c0});
  end

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic px(input logic s, input logic e, input logic v, input logic c, input logic [CBW-1:0] d);
    fs = s; fe = e; vld = v; cor = c; diff = d;
    tick();
  endtask

  task automatic idle(input int unsigned n);
    fs = 1'b0; fe = 1'b0; vld = 1'b0; cor = 1'b0; diff = '0;
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic expect_frame(input string nm, input int unsigned e, input logic [SUM_W-1:0] es,
                              input logic [CNT_W-1:0] ec1, input logic [CNT_W-1:0] ec0);
    pulse_t p;
    if (pq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_pulse: got none expected 1", nm);
    end else begin
      p = pq.pop_front();
      chk({nm, "_edge"}, 64'(p.e), 64'(e));
      chk({nm, "_both"}, {62'd0, p.f1, p.f0}, 64'd3);
      chk({nm, "_sum_sat"}, 64'(p.s1), 64'(es));
      chk({nm, "_cnt_sat"}, 64'(p.c1), 64'(ec1));
      chk({nm, "_sum_wrap"}, 64'(p.s0), 64'(es));
      chk({nm, "_cnt_wrap"}, 64'(p.c0), 64'(ec0));
    end
  endtask

  initial begin
    int unsigned end_e;
    int unsigned end_b;

    // {n, diffs (byte i = pixel i), corresp mask, valid mask, sum, count}
    ft[0] = '{3, {8'd0, 8'd5, 8'hFC, 8'd3}, 4'b0111, 4'b0111, 32'd50, 6'd3};
    ft[1] = '{4, {8'd7, 8'd7, 8'd7, 8'd7}, 4'b1101, 4'b1011, 32'd98, 6'd2};
    ft[2] = '{1, {8'd0, 8'd0, 8'd0, 8'h80}, 4'b0001, 4'b0001, 32'd16384, 6'd1};
    ft[3] = '{1, {8'd0, 8'd0, 8'd0, 8'd9}, 4'b0000, 4'b0001, 32'd0, 6'd0};
    ft[4] = '{4, {8'h81, 8'd0, 8'd127, 8'hFF}, 4'b1111, 4'b1111, 32'd32259, 6'd4};

    // Reset with active inputs: they must be ignored.
    fs = 1'b1; fe = 1'b1; vld = 1'b1; cor = 1'b1; diff = 8'd5;
    tick();
    tick();
    chk("rst_fe", {62'd0, fe1, fe0}, 64'd0);
    chk("rst_sum", 64'(s1 | s0), 64'd0);
    chk("rst_cnt", 64'(c1 | c0), 64'd0);
    rst = 1'b0;
    idle(5);
    chk("post_rst_no_pulse", 64'(pq.size()), 64'd0);

    for (int unsigned f = 0; f < 5; f++) begin
      for (int unsigned i = 0; i < ft[f].n; i++) begin
        px(i == 0, i == ft[f].n - 1, ft[f].val[i], ft[f].cor[i], ft[f].d[8*i +: 8]);
      end
      end_e = edge_n;
      idle(5);
      expect_frame($sformatf("table%0d", f), end_e + 2, ft[f].es, ft[f].ec, ft[f].ec);
    end

    // End pulse while IDLE: no pulse, results hold.
    px(1'b0, 1'b1, 1'b1, 1'b1, 8'd5);
    idle(5);
    chk("idle_end_no_pulse", 64'(pq.size()), 64'd0);
    chk("hold_sum", 64'(s1), 64'd32259);
    chk("hold_cnt", 64'(c0), 64'd4);

    // Back-to-back: A {1,2}, then single-pixel B {10} on the very next cycle.
    px(1'b1, 1'b0, 1'b1, 1'b1, 8'd1);
    px(1'b0, 1'b1, 1'b1, 1'b1, 8'd2);
    end_e = edge_n;
    px(1'b1, 1'b1, 1'b1, 1'b1, 8'd10);
    end_b = edge_n;
    idle(5);
    expect_frame("b2b_a", end_e + 2, 32'd5, 6'd2, 6'd2);
    expect_frame("b2b_b", end_b + 2, 32'd100, 6'd1, 6'd1);

    // Restart mid-frame: the {9,9} partial is dropped silently.
    px(1'b1, 1'b0, 1'b1, 1'b1, 8'd9);
    px(1'b0, 1'b0, 1'b1, 1'b1, 8'd9);
    px(1'b1, 1'b0, 1'b1, 1'b1, 8'd2);
    px(1'b0, 1'b1, 1'b1, 1'b1, 8'd3);
    end_e = edge_n;
    idle(5);
    expect_frame("restart", end_e + 2, 32'd13, 6'd2, 6'd2);
    chk("restart_single_pulse", 64'(pq.size()), 64'd0);

    // Reset mid-frame, end pulse presented during reset.
    px(1'b1, 1'b0, 1'b1, 1'b1, 8'd4);
    px(1'b0, 1'b0, 1'b1, 1'b1, 8'd4);
    rst = 1'b1;
    px(1'b0, 1'b1, 1'b1, 1'b1, 8'd4);
    rst = 1'b0;
    idle(5);
    chk("midrst_no_pulse", 64'(pq.size()), 64'd0);
    chk("midrst_sum", 64'(s1 | s0), 64'd0);
    chk("midrst_cnt", 64'(c1 | c0), 64'd0);
    px(1'b1, 1'b1, 1'b1, 1'b1, 8'd6);
    end_e = edge_n;
    idle(5);
    expect_frame("after_rst", end_e + 2, 32'd36, 6'd1, 6'd1);

    // 70 zero residuals: saturating count clamps at 63, wrapping count gives 70 mod 64.
    for (int unsigned i = 0; i < 70; i++) px(i == 0, i == 69, 1'b1, 1'b1, 8'd0);
    end_e = edge_n;
    idle(5);
    expect_frame("count_sat", end_e + 2, 32'd0, 6'd63, 6'd6);

    // Next start tag releases the clamp.
    px(1'b1, 1'b1, 1'b1, 1'b1, 8'hFE);
    end_e = edge_n;
    idle(5);
    expect_frame("post_sat", end_e + 2, 32'd4, 6'd1, 6'd1);
    chk("final_no_extra_pulse", 64'(pq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sigma_icp_accumulator.md
SIGMA_ICP_ACCUMULATOR -- requirements
Module: sigma_icp_accumulator

Interface
REQ-001 Parameter: SATURATE, default 1, 1 = accumulators clamp at maximum, 0 = accumulators wrap modulo width.
REQ-002 Parameter: CLOUD_BW, H_SIZE_BW, V_SIZE_BW, default from RgbdVoConfigPk, sets residual width and count width.
REQ-003 i_clk  input  1  single clock; all logic on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_frame_start  input  1  one-cycle pulse; the pixel presented in the same cycle is the first of the frame.
REQ-006 i_frame_end  input  1  one-cycle pulse; the pixel presented in the same cycle is the last of the frame.
REQ-007 i_valid  input  1  pixel qualifier.
REQ-008 i_corresp  input  1  pixel has a valid ICP correspondence; ignored when i_valid=0.
REQ-009 i_diff  input  CLOUD_BW  signed two's-complement ICP residual for the pixel.
REQ-010 o_frame_end  output  1  one-cycle pulse; outputs below are updated in the same cycle.
REQ-011 o_sigma_s_icp  output  4*CLOUD_BW  sum of squared residuals for the completed frame, nonnegative.
REQ-012 o_corresp_count  output  H_SIZE_BW+V_SIZE_BW  number of contributing pixels in the completed frame.

Function
REQ-013 Contributing pixel: i_valid=1 AND i_corresp=1 AND (state ACTIVE, OR i_frame_start=1 in the same cycle).
REQ-014 FSM states: IDLE, ACTIVE. IDLE->ACTIVE on i_frame_start. ACTIVE->IDLE on i_frame_end without i_frame_start. ACTIVE stays ACTIVE on i_frame_start (restart).
REQ-015 i_frame_start and i_frame_end in the same cycle: single-pixel frame; the pixel counts if contributing; FSM ends in IDLE.
REQ-016 i_frame_end in IDLE without i_frame_start: ignored; no o_frame_end pulse.
REQ-017 Pipeline: d1 input register; d2 registered square i_diff*i_diff, signed multiply, 2*CLOUD_BW-bit nonnegative result; d3 accumulate.
REQ-018 A start tag and an end tag travel with each pixel through d1-d2.
REQ-019 At d3 with the start tag: the accumulator loads the pixel's square (or 0), discarding the prior partial sum; the count loads 1 (or 0).
REQ-020 At d3 without the start tag: the accumulator adds the square (zero-extended to 4*CLOUD_BW); the count adds 1.
REQ-021 Latency: o_frame_end asserts exactly 3 cycles after the accepted i_frame_end. The last pixel is included.
REQ-022 At o_frame_end, o_sigma_s_icp and o_corresp_count take the final d3 values. They then hold until the next o_frame_end.
REQ-023 Back-to-back frames: i_frame_start in the cycle right after i_frame_end is accepted. The first frame's result is unaffected.
REQ-024 i_frame_start while ACTIVE (restart): the partial frame is discarded without an o_frame_end pulse.
REQ-025 SATURATE=1: the sum clamps at 2^(4*CLOUD_BW-1)-1, the positive maximum for signed downstream division.
REQ-026 SATURATE=1: the count clamps at all-ones; once clamped, each value stays clamped until the next start tag.
REQ-027 SATURATE=0: the sum and count wrap modulo their widths.
REQ-028 Largest square: i_diff=-2^(CLOUD_BW-1) gives 2^(2*CLOUD_BW-2), held exactly with no overflow in d2.
REQ-029 Non-contributing pixels (i_valid=0, or i_corresp=0) leave the sum and count unchanged, but their frame tags still propagate.

Reset
REQ-030 Synchronous i_rst=1 sets FSM to IDLE and clears all pipeline registers and tags.
REQ-031 Synchronous i_rst=1 sets o_frame_end=0, o_sigma_s_icp=0, o_corresp_count=0.
REQ-032 Reset mid-frame drops the frame: no o_frame_end for it; the next accepted frame's result is correct.
REQ-033 Inputs in the reset cycle are ignored.

Verification
REQ-034 Basic: start; contributing i_diff 3, -4, 5; end on the -4... corrected order: start on 3, -4 next, end on 5 -> o_frame_end 3 cycles after the end pulse, o_sigma_s_icp=50, o_corresp_count=3.
REQ-035 Masking: 4 pixels i_diff=7; i_corresp pattern 1,0,1,1; i_valid of pixel 3 = 0 -> sum 98, count 2.
REQ-036 Edge cases, two frames: (a) start and end in one cycle, i_diff=-2^(CLOUD_BW-1) -> sum 2^(2*CLOUD_BW-2), count 1; (b) end in IDLE -> no pulse.
REQ-037 Back-to-back: frame A {1,2} with start of B on the next cycle; frame B {10} -> two pulses 1 cycle apart.
REQ-038 Back-to-back results: frame A gives 5/2, then frame B gives 100/1. Restart mid-frame discards the partial sum with no pulse.
REQ-039 Saturation: SATURATE=1, count preloaded near all-ones by a long frame of i_diff=0 -> count clamps at all-ones and sum=0. SATURATE=0 -> count wraps.
REQ-040 Reset mid-frame: i_rst for 1 cycle after 2 pixels -> outputs 0, no pulse. A following frame {6} -> 36/1.
